// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-side PC owner: imem req/ack sequencing, decode handoff, redirect select
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        pc_sel,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_sel_q, pc_sel_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pending_q, pending_d;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pc_sel_q  <= 1'b0;
      count_q   <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_sel_q  <= pc_sel_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_sel_d  = pc_sel_q;
    count_d   = count_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (flush) begin
          pc_d     = align(flush_target);
          pc_sel_d = 1'b1;
        end
      end
      FETCH: begin
        if (imem_ack && flush) begin
          // Returned data belongs to the squashed path; refetch from the redirect.
          pc_d     = align(flush_target);
          pc_sel_d = 1'b1;
        end else if (imem_ack) begin
          state_d = ISSUE;
        end else if (flush) begin
          pending_d = align(flush_target);
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        // The outstanding request cannot be withdrawn; the newest redirect wins.
        if (flush) pending_d = align(flush_target);
        if (imem_ack) begin
          pc_d     = flush ? align(flush_target) : pending_q;
          pc_sel_d = 1'b1;
          state_d  = FETCH;
        end
      end
      ISSUE: begin
        if (flush) begin
          pc_d     = align(flush_target);
          pc_sel_d = 1'b1;
          state_d  = FETCH;
        end else if (!stall) begin
          count_d = count_q + 32'd1;
          state_d = FETCH;
          if (jump) begin
            pc_d     = align(jump_target);
            pc_sel_d = 1'b1;
          end else if (branch_taken) begin
            pc_d     = align(branch_target);
            pc_sel_d = 1'b1;
          end else begin
            pc_d     = pc_q + 32'd4;
            pc_sel_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign instr_valid = (state_q == ISSUE);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign pc_sel      = pc_sel_q;
  assign fetch_count = count_q;

endmodule
